// File: rtl/clock_rate_meter_if.sv
// ============================================================================
//  Module      : clock_rate_meter_if
//  Description : Measurement-side signal bundle of the clock rate meter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface clock_rate_meter_if;
    logic        inClk;
    logic        measure_en;
    logic [31:0] rate;
    logic        rate_valid;
    logic        timeout;

    modport master (
        output inClk,
        output measure_en,
        input  rate,
        input  rate_valid,
        input  timeout
    );

    modport slave (
        input  inClk,
        input  measure_en,
        output rate,
        output rate_valid,
        output timeout
    );
endinterface

`default_nettype wire

// File: rtl/clock_rate_meter.sv
// ============================================================================
//  Module      : clock_rate_meter
//  Description : Measures the period of a slow square wave and reports its
//                rate in Hz as BASE_SPEED / period, with a no-edge timeout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_rate_meter #(
    parameter int unsigned BASE_SPEED     = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    clock_rate_meter_if.slave  mbus
);

    localparam logic [31:0] c_base_speed = 32'(BASE_SPEED);
    localparam logic [31:0] c_to_limit   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_pc_max     = '1;
    localparam logic [4:0]  c_last_step  = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DIVIDE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_sync;
    logic        r_edge;
    logic [31:0] r_pc;
    logic [31:0] r_div;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [4:0]  r_step;
    logic [31:0] r_rate;
    logic        r_rate_valid;
    logic        r_timeout;

    logic        w_start_div;
    logic        w_finish;
    logic        w_fire_timeout;
    logic [31:0] w_period;
    logic [32:0] w_rem_shift;
    logic        w_ge;
    logic [31:0] w_rem_sub;
    logic [31:0] w_rem_next;
    logic [31:0] w_quot_next;

    assign w_period = (r_pc == c_pc_max) ? c_pc_max : r_pc + 32'd1;

    // One restoring step: the dividend shifts out of r_quot as quotient bits shift in.
    assign w_rem_shift = {r_rem, r_quot[31]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_div});
    assign w_rem_sub   = w_rem_shift[31:0] - r_div;
    assign w_rem_next  = w_ge ? w_rem_sub : w_rem_shift[31:0];
    assign w_quot_next = {r_quot[30:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_start_div    = 1'b0;
        w_finish       = 1'b0;
        w_fire_timeout = 1'b0;
        if (!mbus.measure_en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_ARM;
                ST_ARM: begin
                    if (r_edge) begin
                        w_state_next = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // A closing edge wins over a timeout reached in the same cycle.
                    if (r_edge) begin
                        w_start_div  = 1'b1;
                        w_state_next = ST_DIVIDE;
                    end else if (r_pc >= c_to_limit) begin
                        w_fire_timeout = 1'b1;
                        w_state_next   = ST_ARM;
                    end
                end
                ST_DIVIDE: begin
                    if (r_step == c_last_step) begin
                        w_finish     = 1'b1;
                        w_state_next = ST_COUNT;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync       <= '0;
            r_edge       <= 1'b0;
            r_pc         <= '0;
            r_div        <= '0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_step       <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_sync       <= {r_sync[1:0], mbus.inClk};
            r_edge       <= r_sync[1] & ~r_sync[2];
            r_pc         <= r_edge ? 32'd0 : ((r_pc == c_pc_max) ? r_pc : r_pc + 32'd1);
            r_rate_valid <= 1'b0;

            if (w_start_div) begin
                r_div  <= w_period;
                r_rem  <= '0;
                r_quot <= c_base_speed;
                r_step <= '0;
            end else if (r_state == ST_DIVIDE) begin
                r_rem  <= w_rem_next;
                r_quot <= w_quot_next;
                r_step <= r_step + 5'd1;
            end

            if (w_finish) begin
                r_rate       <= w_quot_next;
                r_timeout    <= 1'b0;
                r_rate_valid <= 1'b1;
            end else if (w_fire_timeout) begin
                r_rate       <= '0;
                r_timeout    <= 1'b1;
                r_rate_valid <= 1'b1;
            end
        end
    end

    assign mbus.rate       = r_rate;
    assign mbus.rate_valid = r_rate_valid;
    assign mbus.timeout    = r_timeout;

endmodule

`default_nettype wire
